// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared widths, Q-format constants, the reducer state encoding and the
// fold/round helper. The helper is also used by the downstream
// sign-correction stage, so it is a package function and not inlined in
// the reducer.
//   IN_W   : width of the Q16.16 input angle
//   REM_W  : width of the unsigned Q16.32 remainder
//   OUT_W  : width of the Q2.14 reduced angle
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int IN_W  = 32;
    localparam int REM_W = 48;
    localparam int OUT_W = 16;
    localparam int K_W   = 4;

    // Fold arithmetic carries two extra bits so +-2pi fits as a signed value.
    localparam int A_W       = REM_W + 2;
    // Q16.32 -> Q2.14 drops 18 fraction bits.
    localparam int FRAC_DROP = 18;

    localparam logic [K_W-1:0] K_INIT = 4'd12;

    localparam logic [REM_W-1:0] TWO_PI_Q32  = 48'h0006487ED511;
    localparam logic [REM_W-1:0] PI_Q32      = 48'h0003243F6A89;
    localparam logic [REM_W-1:0] HALF_PI_Q32 = 48'h00001921FB544;

    localparam logic signed [A_W-1:0] ROUND_HALF = 50'sd131072;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_FOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [OUT_W-1:0] angle;
        logic             cos_neg;
    } fold_t;

    // Apply the sign, wrap into [-pi, pi], mirror into [-pi/2, pi/2] and
    // round half up to Q2.14. A mirrored angle means cosine changes sign
    // while sine is unchanged.
    function automatic fold_t fold_round(input logic s, input logic [REM_W-1:0] r);
        logic signed [A_W-1:0] a;
        logic signed [A_W-1:0] pi_s;
        logic signed [A_W-1:0] hpi_s;
        logic signed [A_W-1:0] tpi_s;
        fold_t                 res;
        pi_s  = $signed({2'b00, PI_Q32});
        hpi_s = $signed({2'b00, HALF_PI_Q32});
        tpi_s = $signed({2'b00, TWO_PI_Q32});
        a     = $signed({2'b00, r});
        if (s) begin
            a = -a;
        end
        if (a > pi_s) begin
            a = a - tpi_s;
        end
        if (a < -pi_s) begin
            a = a + tpi_s;
        end
        res.cos_neg = 1'b0;
        if (a > hpi_s) begin
            a           = pi_s - a;
            res.cos_neg = 1'b1;
        end else if (a < -hpi_s) begin
            a           = -pi_s - a;
            res.cos_neg = 1'b1;
        end
        res.angle = OUT_W'((a + ROUND_HALF) >>> FRAC_DROP);
        return res;
    endfunction

endpackage

// File: rtl/angle_range_reduce.sv
// ---------------------------------------------------------------------------
// angle_range_reduce
// Reduces a Q16.16 radian angle into [-pi/2, +pi/2] (Q2.14) for a
// downstream sine/cosine stage, flagging when that stage's cosine must be
// negated. The remainder modulo 2pi is found by a 13-step restoring
// division (one quotient bit per cycle), followed by one fold/round cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake, angle_in sampled on accept
//   angle_in              signed Q16.16 radians
//   out_valid / out_ready result handshake
//   angle_out             signed Q2.14 radians, held until the next result
//   cos_neg               downstream cosine must be negated
// ---------------------------------------------------------------------------
module angle_range_reduce
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  angle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] angle_out,
    output logic             cos_neg
);

    state_e             state_q;
    logic [REM_W-1:0]   r_q;
    logic [K_W-1:0]     k_q;
    logic               sign_q;
    logic [OUT_W-1:0]   angle_q;
    logic               cos_neg_q;

    logic [IN_W-1:0]    mag_d;
    logic [REM_W-1:0]   step_d;
    logic [REM_W-1:0]   r_d;
    fold_t              fold_d;

    always_comb begin
        // Two's-complement magnitude; 0x80000000 maps to 2^31, which is
        // still exact as an unsigned value.
        mag_d  = angle_in[IN_W-1] ? (~angle_in + 1'b1) : angle_in;
        // The remainder never exceeds twice the current step, so one
        // conditional subtract per weight gives the exact remainder.
        step_d = TWO_PI_Q32 << k_q;
        r_d    = (r_q >= step_d) ? (r_q - step_d) : r_q;
        fold_d = fold_round(sign_q, r_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            k_q       <= '0;
            sign_q    <= 1'b0;
            angle_q   <= '0;
            cos_neg_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= angle_in[IN_W-1];
                        r_q     <= {mag_d, {(REM_W-IN_W){1'b0}}};
                        k_q     <= K_INIT;
                        state_q <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    r_q <= r_d;
                    if (k_q == '0) begin
                        state_q <= ST_FOLD;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                ST_FOLD: begin
                    angle_q   <= fold_d.angle;
                    cos_neg_q <= fold_d.cos_neg;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign angle_out = angle_q;
    assign cos_neg   = cos_neg_q;

endmodule

// File: tb/tb_angle_range_reduce.sv
// ---------------------------------------------------------------------------
// tb_angle_range_reduce
// Directed vectors with hand-computed Q2.14 results. The driver pushes each
// expected result into a queue on the accepting edge; an independent
// monitor pops and compares on every output handshake and checks the
// accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_angle_range_reduce;
    import cordic_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] angle_out;
    logic        cos_neg;

    angle_range_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle_out (angle_out),
        .cos_neg   (cos_neg)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        seen = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] e;
    fold_t       fr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: latency on first sight of out_valid, value on handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                chk("latency", 48'(cyc - acc_cyc), 48'd14);
                seen = 1'b1;
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 48'(angle_out), 48'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("angle_out", 48'(angle_out), 48'(e[15:0]));
                    chk("cos_neg", 48'(cos_neg), 48'(e[16]));
                end
                seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] ang, input logic [15:0] ea, input logic ec);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 48'(in_ready), 48'd1);
        end else begin
            in_valid = 1'b1;
            angle_in = ang;
            @(posedge clk);
            #1;
            exp_q.push_back({ec, ea});
            acc_cyc  = cyc;
            in_valid = 1'b0;
            angle_in = $urandom;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        angle_in  = '0;
        #12;
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_in_ready", 48'(in_ready), 48'd1);
        chk("rst_angle_out", 48'(angle_out), 48'h0000);
        chk("rst_cos_neg", 48'(cos_neg), 48'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fold boundaries exercised directly on the shared helper.
        fr = fold_round(1'b0, PI_Q32);
        chk("fold_pos_pi", 48'(fr), 48'({16'h0000, 1'b1}));
        fr = fold_round(1'b1, PI_Q32);
        chk("fold_neg_pi", 48'(fr), 48'({16'h0000, 1'b1}));
        fr = fold_round(1'b0, HALF_PI_Q32);
        chk("fold_pos_half_pi", 48'(fr), 48'({16'h6488, 1'b0}));
        fr = fold_round(1'b1, HALF_PI_Q32);
        chk("fold_neg_half_pi", 48'(fr), 48'({16'h9B78, 1'b0}));

        send(32'h00010000, 16'h4000, 1'b0);   //  1.0
        send(32'h00030000, 16'h0910, 1'b1);   //  3.0
        send(32'h00640000, 16'hDE05, 1'b0);   //  100.0
        send(32'hFFFE0000, 16'hB6F0, 1'b1);   // -2.0
        send(32'h80000000, 16'hB3EE, 1'b0);   // -32768.0
        send(32'h00000000, 16'h0000, 1'b0);   //  0.0
        send(32'hFFFF0000, 16'hC000, 1'b0);   // -1.0
        send(32'h00020000, 16'h4910, 1'b1);   //  2.0
        wait_idle();
        chk("hold_angle_idle", 48'(angle_out), 48'h4910);
        chk("hold_cos_idle", 48'(cos_neg), 48'd1);

        // Requests offered while busy must be ignored.
        send(32'h00010000, 16'h4000, 1'b0);
        in_valid = 1'b1;
        angle_in = 32'h00030000;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Back-pressure in DONE.
        out_ready = 1'b0;
        send(32'h00030000, 16'h0910, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid", 48'(out_valid), 48'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_angle", 48'(angle_out), 48'h0910);
            chk("stall_in_ready", 48'(in_ready), 48'd0);
            chk("stall_out_valid", 48'(out_valid), 48'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 48'(in_ready), 48'd1);
        chk("release_out_valid", 48'(out_valid), 48'd0);
        chk("release_hold_angle", 48'(angle_out), 48'h0910);
        wait_idle();

        // Reset mid-REDUCE discards the request.
        @(negedge clk);
        in_valid = 1'b1;
        angle_in = 32'h00010000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 48'(out_valid), 48'd0);
        chk("midrst_in_ready", 48'(in_ready), 48'd1);
        chk("midrst_angle_out", 48'(angle_out), 48'h0000);
        chk("midrst_cos_neg", 48'(cos_neg), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        send(32'hFFFE0000, 16'hB6F0, 1'b1);
        send(32'h00640000, 16'hDE05, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/angle_range_reduce.md
ANGLE_RANGE_REDUCE -- requirements
Module: angle_range_reduce

Interface
REQ-001 SHALL have parameters: none; all widths and constants come from the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  angle_in holds a valid request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 angle_in  input  32  signed radians, Q16.16.
REQ-007 out_valid  output  1  angle_out/cos_neg hold a valid result.
REQ-008 out_ready  input  1  downstream sine/cosine stage accepts the result.
REQ-009 angle_out  output  16  signed radians, Q2.14, within [-pi/2, +pi/2].
REQ-010 cos_neg  output  1  downstream cosine result SHALL be negated; sine never needs correction.

Function
REQ-011 SHALL implement FSM IDLE -> REDUCE -> FOLD -> DONE -> IDLE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-012 IDLE: on in_valid && in_ready, latch sign s = angle_in[31] and magnitude |angle_in| into a 48-bit unsigned Q16.32 remainder r; set k=12; go to REDUCE.
REQ-013 REDUCE: each cycle, if r >= (TWO_PI_Q32 << k) then r -= (TWO_PI_Q32 << k); decrement k; after k=0 (13 cycles) go to FOLD; r is then in [0, 2pi).
REQ-014 FOLD (one cycle, registered result): a = s ? -r : r; if a > PI then a -= 2pi; if a < -PI then a += 2pi.
REQ-015 FOLD: if a > HALF_PI then a = PI - a and cos_neg=1; else if a < -HALF_PI then a = -PI - a and cos_neg=1; else cos_neg=0; comparisons strict.
REQ-016 FOLD: angle_out = (a + 2^17) >>> 18 (round half up to Q2.14); no saturation required.
REQ-017 Latency: out_valid SHALL rise after the 14th rising edge following the accepting edge.
REQ-018 DONE: angle_out, cos_neg held stable while out_ready=0; on out_ready=1 return to IDLE; in_ready SHALL be low throughout DONE (no same-cycle accept).
REQ-019 angle_out/cos_neg SHALL retain last result when out_valid=0.
REQ-020 angle_in = 0x80000000 (-32768.0) SHALL reduce correctly (magnitude 2^15 fits the remainder).
REQ-021 Exact boundaries: a = +-pi maps to angle_out 0, cos_neg=1; a = +-pi/2 passes through unfolded, cos_neg=0.
REQ-022 in_valid while not in IDLE SHALL be ignored; angle_in sampled only at the accepting edge.

Reset
REQ-023 rst=1 SHALL force state=IDLE, k=0, r=0, angle_out=0, cos_neg=0 immediately; out_valid=0, in_ready=1.
REQ-024 Reset mid-REDUCE/FOLD/DONE SHALL discard the request; no partial result emitted.

Structure
REQ-025 Package cordic_pkg SHALL hold TWO_PI_Q32=0x6487ED511, PI_Q32=0x3243F6A89, HALF_PI_Q32=0x1921FB544, widths (32 in, 48 remainder, 16 out), state enum.
REQ-026 No sub-module; the FOLD/round step MAY be a package function reused by the downstream sign-correction stage.

Verification
REQ-027 angle_in 0x00010000 (1.0) -> angle_out 0x4000, cos_neg 0, out_valid after exactly 14 edges.
REQ-028 angle_in 0x00030000 (3.0) -> angle_out 0x0910 (2320), cos_neg 1.
REQ-029 angle_in 0x00640000 (100.0) -> angle_out 0xDE05 (-8699), cos_neg 0.
REQ-030 angle_in 0xFFFE0000 (-2.0) -> angle_out 0xB6F0 (-18704), cos_neg 1.
REQ-031 out_ready low 5 cycles in DONE -> outputs stable, in_ready 0; out_ready high -> in_ready 1 next cycle.
REQ-032 rst pulse mid-REDUCE -> same cycle out_valid 0, in_ready 1, angle_out 0x0000; next request yields correct result.
